neuron_unit: RTL and testbench
==============================

Name: neuron_unit

Overview:
- Single neuron processing element: the responder on the `start_*` / `ready_*` handshake that the network controller drives.
- On a one-cycle `start` pulse it consumes exactly N_IN (input, weight) beats and multiply-accumulates them.
- It then adds the bias, applies saturation and optional ReLU, and holds the result with `ready` high until the next `start`.
- It is instantiated once per hidden neuron (128) and once per output neuron (10). Each instance's `ready` feeds one bit of the controller's ready vector.

Parameters:
- N_IN, 784, number of MAC beats per evaluation (use 128 for the output layer).
- DATA_W, 16, width of signed fixed-point in/weight/bias/result.
- FRAC, 8, fractional bits of the DATA_W format (Q7.8 at defaults).
- ACC_W, 42, accumulator width; must be ≥ 2*DATA_W + clog2(N_IN).
- RELU, 1, 1 = clamp negative results to 0; 0 = linear output.

Ports:
- clk  input  1  clock, all state changes on its rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse that begins an evaluation
- data_valid  input  1  in_data/w_data hold a valid beat this cycle
- in_data  input  DATA_W  signed activation beat
- w_data  input  DATA_W  signed weight beat
- bias  input  DATA_W  signed bias, sampled in BIAS state
- busy  output  1  high in ACCUM, BIAS, ACT
- ready  output  1  result valid; level signal, held until next start
- out_data  output  DATA_W  signed result
- sat  output  1  result was saturated; valid while ready is high
- beat_cnt  output  clog2(N_IN)  beats accepted so far in the current evaluation

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE.
  - acc, beat_cnt, out_data, sat, ready and busy all 0.
  - Reset wins over every other input.
  - Reset mid-evaluation discards the partial sum. No ready pulse follows.
- States:
  - IDLE/DONE: waiting. ready=0 in IDLE, ready=1 in DONE.
  - start=1 → ACCUM, with acc=0 and beat_cnt=0. The start cycle never samples a data beat.
  - In DONE, the edge that samples start also clears ready and sat. out_data keeps its old value until overwritten.
- ACCUM:
  - Each edge with data_valid=1 does acc += sext(in_data*w_data), using a full 2*DATA_W signed product, and beat_cnt += 1.
  - data_valid=0 cycles are stalls: no change.
  - The edge that accepts beat N_IN-1 (0-based) moves to BIAS.
  - start while in ACCUM is ignored.
  - The accumulator wraps modulo 2^ACC_W. It is sized so that this cannot occur for in-range data.
- BIAS: one cycle. acc += sext(bias) << FRAC. data_valid is ignored. Next state ACT.
- ACT: one cycle.
  - r = acc >>> FRAC, arithmetic shift, truncating toward −inf.
  - If r > 2^(DATA_W-1)−1: out_data = 0x7FF…F and sat=1.
  - If r < −2^(DATA_W-1): out_data = 0x800…0 and sat=1.
  - If RELU=1 and the result is negative: out_data = 0 and sat=0.
  - ready is set on the same edge. Next state DONE.
- Latency: if the last beat is accepted on edge E, then out_data, sat and ready are valid after edge E+2.
- data_valid is ignored in IDLE, BIAS, ACT and DONE.
- Simultaneous start and data_valid in IDLE/DONE: start is taken, the beat is dropped.

Test Plan:
- N_IN=4, RELU=1. Feed in={1.0,2.0,3.0,4.0} (0x0100..0x0400), w all 0x0100, bias 0x0080, beats on consecutive cycles → ready after edge E+2, out_data=0x0A80, sat=0, busy low in DONE.
- Same data with data_valid gaps (pattern 1,0,0,1,1,0,1) → identical 0x0A80. beat_cnt advances only on valid cycles.
- w all 0xFF00 (−1.0), bias 0:
  - RELU=1 → out_data=0x0000, sat=0.
  - RELU=0 → out_data=0xF600.
- in and w all 0x7F00, bias 0 → out_data=0x7FFF, sat=1. Next start clears ready and sat on its edge.
- Pulse start again after the 2nd beat → ignored; the result after 4 beats is unchanged.
- Assert rst after the 2nd beat, then start and 4 new beats → result reflects only the new beats. ready stays 0 through the reset.

Source files
------------

// File: rtl/neuron_unit.sv
// Single neuron processing element: streaming MAC over N_IN (input, weight) beats,
// then bias add, saturation to DATA_W and optional ReLU; result held with ready high.
module neuron_unit #(
  parameter int unsigned N_IN   = 784,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned ACC_W  = 42,
  parameter int unsigned RELU   = 1,
  localparam int unsigned CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_data_valid,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic [DATA_W-1:0] i_w_data,
  input  logic [DATA_W-1:0] i_bias,
  output logic              o_busy,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_sat,
  output logic [CNT_W-1:0]  o_beat_cnt
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned UPPER_W = ACC_W - DATA_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_BIAS,
    S_ACT,
    S_DONE
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic signed [ACC_W-1:0]  r_acc, w_acc_nxt;
  logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]        r_out, w_out_nxt;
  logic                     r_sat, w_sat_nxt;
  logic                     r_ready, w_ready_nxt;
  logic                     r_busy, w_busy_nxt;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_bias_ext;
  logic signed [ACC_W-1:0]  w_shift;
  logic [UPPER_W-1:0]       w_upper;
  logic [DATA_W-1:0]        w_res;
  logic                     w_res_sat;

  // Full-precision product and bias, both aligned to the accumulator's 2*FRAC scale
  assign w_prod     = $signed(i_in_data) * $signed(i_w_data);
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_bias_ext = {{(ACC_W-DATA_W){i_bias[DATA_W-1]}}, i_bias} << FRAC;

  // Result fits DATA_W only when the sign bit and all bits above it agree
  assign w_shift = r_acc >>> FRAC;
  assign w_upper = w_shift[ACC_W-1:DATA_W-1];

  always_comb begin
    w_res     = w_shift[DATA_W-1:0];
    w_res_sat = 1'b0;
    if ((RELU != 0) && w_shift[ACC_W-1]) begin
      w_res = '0;
    end else if (!w_shift[ACC_W-1] && (|w_upper)) begin
      w_res     = {1'b0, {(DATA_W-1){1'b1}}};
      w_res_sat = 1'b1;
    end else if (w_shift[ACC_W-1] && !(&w_upper)) begin
      w_res     = {1'b1, {(DATA_W-1){1'b0}}};
      w_res_sat = 1'b1;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    w_sat_nxt   = r_sat;
    w_ready_nxt = r_ready;
    w_busy_nxt  = r_busy;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_nxt = S_ACCUM;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_sat_nxt   = 1'b0;
          w_ready_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_ACCUM: begin
        if (i_data_valid) begin
          w_acc_nxt = r_acc + w_prod_ext;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(N_IN - 1)) begin
            w_state_nxt = S_BIAS;
          end
        end
      end
      S_BIAS: begin
        w_acc_nxt   = r_acc + w_bias_ext;
        w_state_nxt = S_ACT;
      end
      S_ACT: begin
        w_out_nxt   = w_res;
        w_sat_nxt   = w_res_sat;
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_ready_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_sat   <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_sat   <= w_sat_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign o_busy     = r_busy;
  assign o_ready    = r_ready;
  assign o_out_data = r_out;
  assign o_sat      = r_sat;
  assign o_beat_cnt = r_cnt;

endmodule

// File: tb/tb_neuron_unit.sv
// Directed bench for neuron_unit: N_IN=4, one ReLU and one linear instance on shared stimulus.
module tb_neuron_unit;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst, start, dv;
  logic [DW-1:0] in_d, w_d, bias;

  logic          busy1, ready1, sat1, busy0, ready0, sat0;
  logic [DW-1:0] out1, out0;
  logic [1:0]    cnt1, cnt0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  neuron_unit #(.N_IN(N), .DATA_W(DW), .FRAC(8), .ACC_W(42), .RELU(1)) u_relu (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_data_valid(dv),
    .i_in_data(in_d), .i_w_data(w_d), .i_bias(bias),
    .o_busy(busy1), .o_ready(ready1), .o_out_data(out1), .o_sat(sat1), .o_beat_cnt(cnt1)
  );

  neuron_unit #(.N_IN(N), .DATA_W(DW), .FRAC(8), .ACC_W(42), .RELU(0)) u_lin (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_data_valid(dv),
    .i_in_data(in_d), .i_w_data(w_d), .i_bias(bias),
    .o_busy(busy0), .o_ready(ready0), .o_out_data(out0), .o_sat(sat0), .o_beat_cnt(cnt0)
  );

  typedef struct {
    string         name;
    logic [DW-1:0] in_v[4];
    logic [DW-1:0] w_v[4];
    logic [DW-1:0] b;
    logic [DW-1:0] e1;
    logic          s1;
    logic [DW-1:0] e0;
    logic          s0;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock of stimulus; returns at the following negedge with strobes cleared.
  task automatic step(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic s);
    dv = v; in_d = a; w_d = b; start = s;
    @(negedge clk);
    dv = 1'b0; start = 1'b0;
  endtask

  // Start pulse carrying a junk beat, which must be dropped.
  task automatic do_start(input string name, input logic [DW-1:0] prev_out1);
    step(1'b1, 16'h7F00, 16'h7F00, 1'b1);
    chk({name, "_start_ready"}, 32'(ready1), 32'(0));
    chk({name, "_start_sat"}, 32'(sat1), 32'(0));
    chk({name, "_start_busy"}, 32'(busy1), 32'(1));
    chk({name, "_start_cnt"}, 32'(cnt1), 32'(0));
    chk({name, "_start_out_kept"}, 32'(out1), 32'(prev_out1));
  endtask

  // After the last beat's edge E: check BIAS, ACT, then the result after E+2.
  task automatic finish_chk(input string name, input logic [DW-1:0] e1, input logic s1,
                            input logic [DW-1:0] e0, input logic s0);
    chk({name, "_E_ready"}, 32'({ready1, busy1}), 32'(2'b01));
    step(1'b1, 16'h7F00, 16'h7F00, 1'b0);
    chk({name, "_E1_ready"}, 32'({ready1, busy1}), 32'(2'b01));
    step(1'b1, 16'h7F00, 16'h7F00, 1'b0);
    chk({name, "_relu_out"}, 32'({ready1, busy1, sat1, out1}), 32'({2'b10, s1, e1}));
    chk({name, "_lin_out"}, 32'({ready0, busy0, sat0, out0}), 32'({2'b10, s0, e0}));
    step(1'b1, 16'h1234, 16'h1234, 1'b0);
    chk({name, "_hold"}, 32'({ready1, out1, ready0, out0}), 32'({1'b1, e1, 1'b1, e0}));
  endtask

  initial begin
    logic [DW-1:0] last1;
    int            k;
    logic [6:0]    gap_pat;

    vecs[0] = '{"basic", '{16'h0100, 16'h0200, 16'h0300, 16'h0400},
                '{16'h0100, 16'h0100, 16'h0100, 16'h0100}, 16'h0080,
                16'h0A80, 1'b0, 16'h0A80, 1'b0};
    vecs[1] = '{"negw", '{16'h0100, 16'h0200, 16'h0300, 16'h0400},
                '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00}, 16'h0000,
                16'h0000, 1'b0, 16'hF600, 1'b0};
    vecs[2] = '{"possat", '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00},
                '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00}, 16'h0000,
                16'h7FFF, 1'b1, 16'h7FFF, 1'b1};
    vecs[3] = '{"negsat", '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00},
                '{16'h8100, 16'h8100, 16'h8100, 16'h8100}, 16'h0000,
                16'h0000, 1'b0, 16'h8000, 1'b1};
    vecs[4] = '{"mixed", '{16'h0180, 16'hFF80, 16'h0040, 16'h0200},
                '{16'h0200, 16'h0100, 16'hFC00, 16'h0080}, 16'hFF00,
                16'h0180, 1'b0, 16'h0180, 1'b0};
    vecs[5] = '{"floor", '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000},
                '{16'h0080, 16'h0000, 16'h0000, 16'h0000}, 16'h0000,
                16'h0000, 1'b0, 16'hFFFF, 1'b0};

    rst = 1'b1; start = 1'b0; dv = 1'b0; in_d = '0; w_d = '0; bias = '0;
    @(negedge clk);
    step(1'b1, 16'h0100, 16'h0100, 1'b1);
    chk("reset_state", 32'({busy1, ready1, sat1, cnt1, out1}), 32'(0));
    rst = 1'b0;
    step(1'b1, 16'h0100, 16'h0100, 1'b0);
    chk("idle_no_ready", 32'({busy1, ready1, cnt1}), 32'(0));

    // Table: back-to-back beats
    last1 = '0;
    for (int i = 0; i < 6; i++) begin
      bias = vecs[i].b;
      do_start(vecs[i].name, last1);
      for (int j = 0; j < 4; j++) begin
        step(1'b1, vecs[i].in_v[j], vecs[i].w_v[j], 1'b0);
      end
      finish_chk(vecs[i].name, vecs[i].e1, vecs[i].s1, vecs[i].e0, vecs[i].s0);
      last1 = vecs[i].e1;
    end

    // Stalls: pattern 1,0,0,1,1,0,1 (LSB first)
    gap_pat = 7'b1011001;
    bias = vecs[0].b;
    do_start("gaps", last1);
    k = 0;
    for (int t = 0; t < 7; t++) begin
      if (gap_pat[t]) begin
        step(1'b1, vecs[0].in_v[k], vecs[0].w_v[k], 1'b0);
        k++;
      end else begin
        step(1'b0, 16'h7F00, 16'h7F00, 1'b0);
      end
      if (t < 6) chk("gaps_cnt", 32'(cnt1), 32'(k));
    end
    finish_chk("gaps", 16'h0A80, 1'b0, 16'h0A80, 1'b0);

    // Start pulsed again mid-accumulation is ignored
    do_start("midstart", 16'h0A80);
    step(1'b1, vecs[0].in_v[0], vecs[0].w_v[0], 1'b0);
    step(1'b1, vecs[0].in_v[1], vecs[0].w_v[1], 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    chk("midstart_cnt", 32'({busy1, cnt1}), 32'({1'b1, 2'd2}));
    step(1'b1, vecs[0].in_v[2], vecs[0].w_v[2], 1'b1);
    step(1'b1, vecs[0].in_v[3], vecs[0].w_v[3], 1'b0);
    finish_chk("midstart", 16'h0A80, 1'b0, 16'h0A80, 1'b0);

    // Reset after the 2nd beat discards the partial sum
    bias = vecs[1].b;
    do_start("rstmid", 16'h0A80);
    step(1'b1, 16'h7F00, 16'h7F00, 1'b0);
    step(1'b1, 16'h7F00, 16'h7F00, 1'b0);
    rst = 1'b1;
    step(1'b1, 16'h7F00, 16'h7F00, 1'b0);
    rst = 1'b0;
    chk("rstmid_state", 32'({busy1, ready1, sat1, cnt1, out1}), 32'(0));
    for (int t = 0; t < 3; t++) begin
      step(1'b0, 16'h0000, 16'h0000, 1'b0);
      chk("rstmid_no_ready", 32'({ready1, ready0, busy1}), 32'(0));
    end
    do_start("rstnew", 16'h0000);
    for (int j = 0; j < 4; j++) begin
      step(1'b1, vecs[1].in_v[j], vecs[1].w_v[j], 1'b0);
    end
    finish_chk("rstnew", 16'h0000, 1'b0, 16'hF600, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
